// File: rtl/test_capture.sv
// Measures clk cycles between rising edges of evt_in; interval appears on cap_* one edge after the closing rise.
// Single-entry output register: a new capture arriving while cap_valid & ~cap_ready is dropped and sets missed.
module test_capture #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             evt_in,
    input  logic             cap_ready,
    input  logic             clr_missed,
    output logic             cap_valid,
    output logic [WIDTH-1:0] cap_data,
    output logic             cap_ovf,
    output logic             missed
);

    localparam logic IDLE    = 1'b0;
    localparam logic MEASURE = 1'b1;

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    logic             state;
    logic [WIDTH-1:0] cnt;
    logic             evt_d;

    logic             rise;
    logic             capture;
    logic [WIDTH:0]   cnt_inc;
    logic [WIDTH-1:0] cap_d;
    logic             cap_o;
    logic             load;
    logic             drop;

    assign rise    = evt_in & ~evt_d & en;
    assign capture = (state == MEASURE) & rise;

    // cnt holds (cycles since the opening rise) - 1, so the interval is cnt+1
    // unless the counter has already pinned at MAX.
    assign cnt_inc = {1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1};
    assign cap_d   = (cnt == MAX) ? MAX : cnt_inc[WIDTH-1:0];
    assign cap_o   = (cnt_inc >= {1'b0, MAX});

    assign load = capture & (~cap_valid | cap_ready);
    assign drop = capture & cap_valid & ~cap_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_d <= 1'b0;
        end else begin
            evt_d <= evt_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (!en) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rise) begin
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        cnt <= '0;
                    end else if (cnt != MAX) begin
                        cnt <= cnt_inc[WIDTH-1:0];
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid <= 1'b0;
            cap_data  <= '0;
            cap_ovf   <= 1'b0;
        end else if (load) begin
            cap_valid <= 1'b1;
            cap_data  <= cap_d;
            cap_ovf   <= cap_o;
        end else if (cap_valid & cap_ready & ~capture) begin
            cap_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            missed <= 1'b0;
        end else if (drop) begin
            missed <= 1'b1;
        end else if (clr_missed) begin
            missed <= 1'b0;
        end
    end

endmodule
